// File: rtl/control_sequencer.sv
// control_sequencer: microsequencer ahead of ControlUnit; fetches IR/IW, walks operand/execute/writeback
// states, handles interrupt entry, RETI and memory wait timeout. Optional halt/single-step: `define SINGLE_STEP_EN.
module control_sequencer #(
    parameter int CAR_BITS   = 6,
    parameter int WAIT_LIMIT = 8,
    parameter int WAIT_BITS  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         MDB,
    input  logic                MemReady,
    input  logic                IRQ,
    input  logic                GIE,
`ifdef SINGLE_STEP_EN
    input  logic                Halt,
    input  logic                Step,
`endif
    output logic [CAR_BITS-1:0] CAR,
    output logic [15:0]         IR,
    output logic [15:0]         IW,
    output logic                MemReq,
    output logic [1:0]          MemSel,
    output logic                MemWr,
    output logic                INTACK,
    output logic                BusErr
);
    typedef enum logic [3:0] {
        RESET    = 4'd0,  FETCH    = 4'd1,  DECODE  = 4'd2,  SRC_EXT = 4'd3,
        SRC_READ = 4'd4,  DST_EXT  = 4'd5,  DST_READ = 4'd6, EXEC    = 4'd7,
        WB       = 4'd8,  POP_SR   = 4'd9,  POP_PC  = 4'd10, INT_PC  = 4'd11,
        INT_SR   = 4'd12, INT_VEC  = 4'd13, HALT    = 4'd14
    } state_t;

    localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

    state_t               state, nextState, afterSrc, boundary, afterInt;
    logic [WAIT_BITS-1:0] waitCnt;
    logic                 fmtI, fmtII, isJump, isReti, constGen, srcExt, srcRead, stackWb, wbNeeded;
    logic [1:0]           as;
    logic [3:0]           rs;
    logic                 memState, timeout;

    // IR is frozen from FETCH to the next FETCH, so decoding it combinationally equals registering it in DECODE.
    always_comb begin
        fmtI     = IR[15:12] >= 4'd4;
        fmtII    = IR[15:10] == 6'b000100;
        isJump   = IR[15:13] == 3'b001;
        isReti   = IR == 16'h1300;
        as       = IR[5:4];
        rs       = fmtI ? IR[11:8] : IR[3:0];
        constGen = (rs == 4'd3) || (rs == 4'd2 && as[1]);
        srcExt   = !constGen && (as == 2'd1 || (as == 2'd3 && rs == 4'd0));
        srcRead  = !constGen && (as == 2'd1 || as == 2'd2 || (as == 2'd3 && rs != 4'd0));
        stackWb  = fmtII && (IR[9:7] == 3'd4 || IR[9:7] == 3'd5);
        wbNeeded = fmtI ? IR[7] : (fmtII && (stackWb || as != 2'd0));
        afterSrc = (fmtI && IR[7]) ? DST_EXT : EXEC;
    end

    always_comb begin
        boundary = FETCH;
        afterInt = FETCH;
`ifdef SINGLE_STEP_EN
        if (Halt) begin
            boundary = HALT;
            afterInt = HALT;
        end
`endif
        if (IRQ && GIE)
            boundary = INT_PC;
    end

    assign memState = state inside {FETCH, SRC_EXT, SRC_READ, DST_EXT, DST_READ, WB,
                                    POP_SR, POP_PC, INT_PC, INT_SR, INT_VEC};
    assign timeout  = (WAIT_LIMIT != 0) && memState && !MemReady && (waitCnt == WAIT_LAST);
    assign CAR      = CAR_BITS'(state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RESET;
            waitCnt <= '0;
            IR      <= '0;
            IW      <= '0;
        end else begin
            state <= nextState;
            if (timeout || nextState != state)
                waitCnt <= '0;
            else if (memState && !MemReady)
                waitCnt <= waitCnt + 1'b1;
            if (state == FETCH && MemReady)
                IR <= MDB;
            if ((state == SRC_EXT || state == DST_EXT) && MemReady)
                IW <= MDB;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            RESET:    nextState = FETCH;
            FETCH:    nextState = DECODE;
            DECODE: begin
                if (isReti)               nextState = POP_SR;
                else if (fmtI || fmtII)   nextState = srcExt ? SRC_EXT : (srcRead ? SRC_READ : afterSrc);
                else if (isJump)          nextState = EXEC;
                else                      nextState = boundary;
            end
            SRC_EXT:  nextState = srcRead ? SRC_READ : afterSrc;
            SRC_READ: nextState = afterSrc;
            DST_EXT:  nextState = DST_READ;
            DST_READ: nextState = EXEC;
            EXEC:     nextState = wbNeeded ? WB : boundary;
            WB:       nextState = boundary;
            POP_SR:   nextState = POP_PC;
            POP_PC:   nextState = boundary;
            INT_PC:   nextState = INT_SR;
            INT_SR:   nextState = INT_VEC;
            INT_VEC:  nextState = afterInt;
`ifdef SINGLE_STEP_EN
            HALT:     nextState = (!Halt || Step) ? FETCH : HALT;
`endif
            default:  nextState = FETCH;
        endcase
        if (memState && !MemReady)
            nextState = state;
        if (timeout)
            nextState = FETCH;
    end

    always_comb begin
        MemReq = memState;
        MemSel = 2'd0;
        MemWr  = 1'b0;
        case (state)
            SRC_READ:        MemSel = 2'd1;
            DST_READ:        MemSel = 2'd2;
            WB: begin
                MemWr  = 1'b1;
                MemSel = fmtI ? 2'd2 : (stackWb ? 2'd3 : 2'd1);
            end
            POP_SR, POP_PC,
            INT_VEC:         MemSel = 2'd3;
            INT_PC, INT_SR: begin
                MemWr  = 1'b1;
                MemSel = 2'd3;
            end
            default: ;
        endcase
        INTACK = (state == INT_VEC) && MemReady;
        BusErr = timeout;
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random instructions
// compared against a state-list reference model built from the instruction rules.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] MDB;
    logic        MemReady;
    logic        IRQ;
    logic        GIE;
`ifdef SINGLE_STEP_EN
    logic        Halt;
    logic        Step;
`endif
    logic [5:0]  CAR;
    logic [15:0] IR;
    logic [15:0] IW;
    logic        MemReq;
    logic [1:0]  MemSel;
    logic        MemWr;
    logic        INTACK;
    logic        BusErr;

    int          checks = 0;
    int          errors = 0;
    int          expQ[$];
    logic [15:0] modelIw = 16'h0000;
    logic [15:0] lastIr = 16'h0000;

    control_sequencer #(.CAR_BITS(6), .WAIT_LIMIT(8), .WAIT_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .MDB(MDB), .MemReady(MemReady), .IRQ(IRQ), .GIE(GIE),
`ifdef SINGLE_STEP_EN
        .Halt(Halt), .Step(Step),
`endif
        .CAR(CAR), .IR(IR), .IW(IW), .MemReq(MemReq), .MemSel(MemSel), .MemWr(MemWr),
        .INTACK(INTACK), .BusErr(BusErr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic bit isLegal(input logic [15:0] ir);
        return (ir[15:12] >= 4'd4) || (ir[15:10] == 6'b000100) || (ir[15:13] == 3'b001);
    endfunction

    function automatic bit isMemSt(input int st);
        return st inside {1, 3, 4, 5, 6, 8, 9, 10, 11, 12, 13};
    endfunction

    function automatic int expSel(input int st, input logic [15:0] ir);
        case (st)
            4:                  return 1;
            6:                  return 2;
            9, 10, 11, 12, 13:  return 3;
            8:                  return (ir[15:12] >= 4'd4) ? 2 : ((ir[9:7] == 3'd4 || ir[9:7] == 3'd5) ? 3 : 1);
            default:            return 0;
        endcase
    endfunction

    // Expected list of microstates for one instruction, ending at the next FETCH.
    function automatic void buildSeq(input logic [15:0] ir, input bit takeIrq);
        bit       isI;
        bit [1:0] as;
        bit [3:0] rs;
        expQ = {};
        expQ.push_back(1);
        expQ.push_back(2);
        if (ir == 16'h1300) begin
            expQ.push_back(9);
            expQ.push_back(10);
        end else if (ir[15:12] >= 4'd4 || ir[15:10] == 6'b000100) begin
            isI = ir[15:12] >= 4'd4;
            as  = ir[5:4];
            rs  = isI ? ir[11:8] : ir[3:0];
            if (!(rs == 3 || (rs == 2 && as >= 2))) begin
                if (as == 1) begin
                    expQ.push_back(3);
                    expQ.push_back(4);
                end else if (as == 2) expQ.push_back(4);
                else if (as == 3)     expQ.push_back(rs == 0 ? 3 : 4);
            end
            if (isI) begin
                if (ir[7]) begin
                    expQ.push_back(5);
                    expQ.push_back(6);
                    expQ.push_back(7);
                    expQ.push_back(8);
                end else expQ.push_back(7);
            end else begin
                expQ.push_back(7);
                if (ir[9:7] == 3'd4 || ir[9:7] == 3'd5 || as != 0) expQ.push_back(8);
            end
        end else if (ir[15:13] == 3'b001) begin
            expQ.push_back(7);
        end
        if (takeIrq) begin
            expQ.push_back(11);
            expQ.push_back(12);
            expQ.push_back(13);
        end
        expQ.push_back(1);
    endfunction

    // Entered at a negedge with the DUT in FETCH; returns with the DUT back in FETCH.
    task automatic runInstr(input logic [15:0] ir, input bit irqIn, input bit gieIn, input bit randReady);
        int          idx = 0;
        int          cycles = 0;
        int          lowRun = 0;
        int          st;
        bit          rdy;
        logic [15:0] ext;
        buildSeq(ir, irqIn && gieIn && isLegal(ir));
        IRQ = irqIn;
        GIE = gieIn;
        forever begin
            st  = expQ[idx];
            rdy = randReady ? (($urandom_range(0, 3) != 0) || lowRun >= 5) : 1'b1;
            lowRun = rdy ? 0 : lowRun + 1;
            ext = 16'($urandom);
            MDB = (st == 1 && idx == 0) ? ir : ext;
            MemReady = rdy;
            if (st == 11) IRQ = 1'b0;
            #1;
            checks++;
            if (CAR !== 6'(st)) begin
                errors++;
                $display("FAIL car ir=%h step=%0d: got %0d expected %0d", ir, idx, CAR, st);
            end
            checks++;
            if (MemReq !== isMemSt(st)) begin
                errors++;
                $display("FAIL memreq ir=%h state=%0d: got %b expected %b", ir, st, MemReq, isMemSt(st));
            end
            checks++;
            if (MemWr !== (st inside {8, 11, 12})) begin
                errors++;
                $display("FAIL memwr ir=%h state=%0d: got %b expected %b", ir, st, MemWr, (st inside {8, 11, 12}));
            end
            if (isMemSt(st) && st != 13) begin
                checks++;
                if (MemSel !== 2'(expSel(st, ir))) begin
                    errors++;
                    $display("FAIL memsel ir=%h state=%0d: got %0d expected %0d", ir, st, MemSel, expSel(st, ir));
                end
            end
            checks++;
            if (INTACK !== (st == 13 && rdy)) begin
                errors++;
                $display("FAIL intack ir=%h state=%0d: got %b expected %b", ir, st, INTACK, (st == 13 && rdy));
            end
            checks++;
            if (BusErr !== 1'b0) begin
                errors++;
                $display("FAIL buserr ir=%h state=%0d: got %b expected 0", ir, st, BusErr);
            end
            if (idx == expQ.size() - 1) break;
            if ((st == 3 || st == 5) && rdy) modelIw = ext;
            if (!isMemSt(st) || rdy) idx++;
            cycles++;
            if (cycles > 200) begin
                errors++;
                $display("FAIL cycle_budget ir=%h: got %0d cycles expected at most 200", ir, cycles);
                break;
            end
            @(negedge clk);
        end
        IRQ = 1'b0;
        lastIr = ir;
        checks++;
        if (IR !== ir) begin
            errors++;
            $display("FAIL ir_latch: got %h expected %h", IR, ir);
        end
        checks++;
        if (IW !== modelIw) begin
            errors++;
            $display("FAIL iw_latch ir=%h: got %h expected %h", ir, IW, modelIw);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; MDB = 16'hFFFF; MemReady = 1'b1; IRQ = 1'b1; GIE = 1'b1;
`ifdef SINGLE_STEP_EN
        Halt = 1'b0; Step = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({CAR, IR, IW, MemReq, MemSel, MemWr, INTACK, BusErr} !== '0) begin
            errors++;
            $display("FAIL reset_values: got car=%0d ir=%h iw=%h req=%b sel=%0d wr=%b ack=%b err=%b expected all 0",
                     CAR, IR, IW, MemReq, MemSel, MemWr, INTACK, BusErr);
        end
        IRQ = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (CAR !== 6'd1) begin
            errors++;
            $display("FAIL reset_exit: got %0d expected 1", CAR);
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            MDB = 16'h440A; MemReady = 1'b0;
            #1;
            checks++;
            if (CAR !== 6'd1 || MemReq !== 1'b1 || IR !== lastIr) begin
                errors++;
                $display("FAIL fetch_wait cycle %0d: got car=%0d req=%b ir=%h expected 1 1 %h", i, CAR, MemReq, IR, lastIr);
            end
            @(negedge clk);
        end
        runInstr(16'h440A, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout_fetch();
        for (int i = 0; i < 8; i++) begin
            MDB = 16'($urandom); MemReady = 1'b0;
            #1;
            checks++;
            if (CAR !== 6'd1 || BusErr !== (i == 7)) begin
                errors++;
                $display("FAIL fetch_timeout cycle %0d: got car=%0d buserr=%b expected 1 %b", i, CAR, BusErr, (i == 7));
            end
            @(negedge clk);
        end
        MemReady = 1'b0;
        #1;
        checks++;
        if (CAR !== 6'd1 || BusErr !== 1'b0 || IR !== lastIr) begin
            errors++;
            $display("FAIL after_timeout: got car=%0d buserr=%b ir=%h expected 1 0 %h", CAR, BusErr, IR, lastIr);
        end
        runInstr(16'h4F0A, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout_mid();
        int seqA[3] = '{1, 2, 5};
        for (int i = 0; i < 3; i++) begin
            MDB = (i == 0) ? 16'h458B : 16'h0010; MemReady = 1'b1;
            #1;
            checks++;
            if (CAR !== 6'(seqA[i])) begin
                errors++;
                $display("FAIL mid_path step %0d: got %0d expected %0d", i, CAR, seqA[i]);
            end
            @(negedge clk);
        end
        IRQ = 1'b1; GIE = 1'b1;
        for (int i = 0; i < 8; i++) begin
            MemReady = 1'b0;
            #1;
            checks++;
            if (CAR !== 6'd6 || BusErr !== (i == 7)) begin
                errors++;
                $display("FAIL dst_timeout cycle %0d: got car=%0d buserr=%b expected 6 %b", i, CAR, BusErr, (i == 7));
            end
            @(negedge clk);
        end
        MemReady = 1'b0;
        #1;
        checks++;
        if (CAR !== 6'd1 || IR !== 16'h458B || IW !== 16'h0010 || BusErr !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got car=%0d ir=%h iw=%h buserr=%b expected 1 458b 0010 0", CAR, IR, IW, BusErr);
        end
        IRQ = 1'b0;
        lastIr = 16'h458B;
        modelIw = 16'h0010;
        runInstr(16'h440A, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int seqA[3] = '{1, 2, 5};
        for (int i = 0; i < 3; i++) begin
            MDB = (i == 0) ? 16'h458B : 16'h0008; MemReady = 1'b1;
            #1;
            checks++;
            if (CAR !== 6'(seqA[i])) begin
                errors++;
                $display("FAIL pre_reset step %0d: got %0d expected %0d", i, CAR, seqA[i]);
            end
            @(negedge clk);
        end
        MemReady = 1'b0;
        #1;
        checks++;
        if (CAR !== 6'd6 || IW !== 16'h0008) begin
            errors++;
            $display("FAIL dst_read_entry: got car=%0d iw=%h expected 6 0008", CAR, IW);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (CAR !== 6'd0 || MemReq !== 1'b0 || IR !== 16'h0 || IW !== 16'h0 || MemWr !== 1'b0 || MemSel !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got car=%0d req=%b ir=%h iw=%h wr=%b sel=%0d expected all 0",
                     CAR, MemReq, IR, IW, MemWr, MemSel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        MemReady = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (CAR !== 6'd1) begin
            errors++;
            $display("FAIL resume_fetch: got %0d expected 1", CAR);
        end
        lastIr = 16'h0000;
        modelIw = 16'h0000;
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        int ssExp[10] = '{1, 2, 7, 14, 14, 1, 2, 7, 14, 1};
        for (int i = 0; i < 10; i++) begin
            MDB = 16'h440A; MemReady = 1'b1;
            Halt = (i < 8);
            Step = (i == 4);
            #1;
            checks++;
            if (CAR !== 6'(ssExp[i]) || (ssExp[i] == 14 && MemReq !== 1'b0)) begin
                errors++;
                $display("FAIL single_step cycle %0d: got car=%0d req=%b expected %0d", i, CAR, MemReq, ssExp[i]);
            end
            if (i < 9) @(negedge clk);
        end
        Step = 1'b0;
        Halt = 1'b0;
        lastIr = 16'h440A;
    endtask
`endif

    task automatic test_random();
        logic [15:0] ir;
        bit          irq;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    ir = {4'($urandom_range(4, 15)), 12'($urandom)};
                2:       ir = {6'b000100, 10'($urandom)};
                3:       ir = {3'b001, 13'($urandom)};
                default: ir = ($urandom_range(0, 3) == 0) ? 16'h1300 : {4'b0000, 12'($urandom)};
            endcase
            irq = isLegal(ir) && ($urandom_range(0, 3) == 0);
            runInstr(ir, irq, 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        runInstr(16'h440A, 1'b0, 1'b0, 1'b0);
        runInstr(16'h458B, 1'b0, 1'b0, 1'b0);
        test_wait_states();
        test_timeout_fetch();
        runInstr(16'h440A, 1'b1, 1'b1, 1'b0);
        runInstr(16'h440A, 1'b1, 1'b0, 1'b0);
        runInstr(16'h1300, 1'b0, 1'b0, 1'b0);
        runInstr(16'h4032, 1'b0, 1'b0, 1'b0);
        runInstr(16'h1290, 1'b0, 1'b0, 1'b0);
        runInstr(16'h0123, 1'b0, 1'b0, 1'b0);
        test_timeout_mid();
        test_reset_mid();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
